// File: rtl/timer_ctrl_if.sv
// Control bus between the countdown-timer controller and its environment:
// button pulses, the live countdown value, the preset and the status outputs.
interface timer_ctrl_if;
    // Inputs are single-cycle pulses sampled on the rising clock edge; there is no back-pressure.
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_start;
    logic [4:0] cur_hours;
    logic [5:0] cur_mins;
    logic [5:0] cur_secs;
    logic [4:0] set_hours;
    logic [5:0] set_mins;
    logic [5:0] set_secs;
    logic       load;
    logic       run;
    logic [1:0] field_sel;
    logic       alarm;
    logic [2:0] state;

    modport master (
        output tick_1hz, btn_mode, btn_inc, btn_start,
        output cur_hours, cur_mins, cur_secs,
        input  set_hours, set_mins, set_secs,
        input  load, run, field_sel, alarm, state
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_inc, btn_start,
        input  cur_hours, cur_mins, cur_secs,
        output set_hours, set_mins, set_secs,
        output load, run, field_sel, alarm, state
    );
endinterface

// File: rtl/timer_ctrl.sv
// Countdown-timer control FSM: preset editing, load/run/pause sequencing and
// a timed alarm once the datapath reports zero.
module timer_ctrl #(
    parameter int ALARM_SECS = 10,
    parameter int MAX_HOURS  = 23
) (
    input  logic         clk,
    input  logic         reset,
    timer_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET_H = 3'd1,
        ST_SET_M = 3'd2,
        ST_SET_S = 3'd3,
        ST_LOAD  = 3'd4,
        ST_RUN   = 3'd5,
        ST_PAUSE = 3'd6,
        ST_ALARM = 3'd7
    } state_t;

    localparam logic [4:0] MAX_H     = 5'(MAX_HOURS);
    localparam logic [5:0] ALARM_CNT = 6'(ALARM_SECS);

    state_t     state_q, state_d;
    logic [4:0] hours_q, hours_d;
    logic [5:0] mins_q, mins_d;
    logic [5:0] secs_q, secs_d;
    logic [5:0] cnt_q, cnt_d;
    logic       load_q, load_d;
    logic       run_q, run_d;
    logic       alarm_q, alarm_d;
    logic [1:0] field_q, field_d;

    logic preset_zero;
    logic cur_zero;
    logic any_btn;

    assign preset_zero = (hours_q == 5'd0) && (mins_q == 6'd0) && (secs_q == 6'd0);
    assign cur_zero    = (bus.cur_hours == 5'd0) && (bus.cur_mins == 6'd0) && (bus.cur_secs == 6'd0);
    assign any_btn     = bus.btn_start | bus.btn_mode | bus.btn_inc;

    // Start outranks mode, which outranks inc; a start with a zero preset swallows the others.
    always_comb begin
        state_d = state_q;
        hours_d = hours_q;
        mins_d  = mins_q;
        secs_d  = secs_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.btn_start) begin
                    if (!preset_zero) state_d = ST_LOAD;
                end else if (bus.btn_mode) begin
                    state_d = ST_SET_H;
                end
            end
            ST_SET_H, ST_SET_M, ST_SET_S: begin
                if (bus.btn_start) begin
                    if (!preset_zero) state_d = ST_LOAD;
                end else if (bus.btn_mode) begin
                    if (state_q == ST_SET_H)      state_d = ST_SET_M;
                    else if (state_q == ST_SET_M) state_d = ST_SET_S;
                    else                          state_d = ST_IDLE;
                end else if (bus.btn_inc) begin
                    if (state_q == ST_SET_H)      hours_d = (hours_q == MAX_H) ? 5'd0 : hours_q + 5'd1;
                    else if (state_q == ST_SET_M) mins_d  = (mins_q == 6'd59) ? 6'd0 : mins_q + 6'd1;
                    else                          secs_d  = (secs_q == 6'd59) ? 6'd0 : secs_q + 6'd1;
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
                if (cur_zero) begin
                    state_d = ST_ALARM;
                    cnt_d   = ALARM_CNT;
                end else if (bus.btn_start) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (bus.btn_start)     state_d = ST_RUN;
                else if (bus.btn_mode) state_d = ST_IDLE;
            end
            ST_ALARM: begin
                if (any_btn) begin
                    state_d = ST_IDLE;
                    cnt_d   = 6'd0;
                end else if (bus.tick_1hz) begin
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q <= 6'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = 6'd0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        load_d  = (state_d == ST_LOAD);
        run_d   = (state_d == ST_RUN);
        alarm_d = (state_d == ST_ALARM);
        field_d = 2'd0;
        if (state_d == ST_SET_H)      field_d = 2'd1;
        else if (state_d == ST_SET_M) field_d = 2'd2;
        else if (state_d == ST_SET_S) field_d = 2'd3;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hours_q <= 5'd0;
            mins_q  <= 6'd0;
            secs_q  <= 6'd0;
            cnt_q   <= 6'd0;
            load_q  <= 1'b0;
            run_q   <= 1'b0;
            alarm_q <= 1'b0;
            field_q <= 2'd0;
        end else begin
            state_q <= state_d;
            hours_q <= hours_d;
            mins_q  <= mins_d;
            secs_q  <= secs_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            run_q   <= run_d;
            alarm_q <= alarm_d;
            field_q <= field_d;
        end
    end

    assign bus.set_hours = hours_q;
    assign bus.set_mins  = mins_q;
    assign bus.set_secs  = secs_q;
    assign bus.load      = load_q;
    assign bus.run       = run_q;
    assign bus.alarm     = alarm_q;
    assign bus.field_sel = field_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios followed by random button/tick traffic,
// every cycle compared against a behavioural model of the controller.
module tb_timer_ctrl;

    localparam int ALARM_SECS = 10;
    localparam int MAX_HOURS  = 23;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    timer_ctrl_if bus ();

    timer_ctrl #(.ALARM_SECS(ALARM_SECS), .MAX_HOURS(MAX_HOURS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    string phase = "reset";

    // Behavioural model: mode number (0..7), preset as plain integers, alarm seconds left.
    int m_mode = 0;
    int m_h = 0, m_m = 0, m_s = 0;
    int m_left = 0;
    int cur_h = 1, cur_m = 0, cur_s = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0d expected %0d", phase, tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit s, input bit m, input bit i, input bit t);
        bit preset_zero;
        bit cur_zero;
        if (r) begin
            m_mode = 0; m_h = 0; m_m = 0; m_s = 0; m_left = 0;
            return;
        end
        preset_zero = (m_h + m_m + m_s) == 0;
        cur_zero    = (cur_h + cur_m + cur_s) == 0;
        if (m_mode == 0) begin
            if (s) begin
                if (!preset_zero) m_mode = 4;
            end else if (m) m_mode = 1;
        end else if (m_mode >= 1 && m_mode <= 3) begin
            if (s) begin
                if (!preset_zero) m_mode = 4;
            end else if (m) begin
                m_mode = (m_mode + 1) % 4;
            end else if (i) begin
                if (m_mode == 1)      m_h = (m_h + 1) % (MAX_HOURS + 1);
                else if (m_mode == 2) m_m = (m_m + 1) % 60;
                else                  m_s = (m_s + 1) % 60;
            end
        end else if (m_mode == 4) begin
            m_mode = 5;
        end else if (m_mode == 5) begin
            if (cur_zero) begin
                m_mode = 7; m_left = ALARM_SECS;
            end else if (s) m_mode = 6;
        end else if (m_mode == 6) begin
            if (s)      m_mode = 5;
            else if (m) m_mode = 0;
        end else begin
            if (s || m || i) m_mode = 0;
            else if (t) begin
                m_left = m_left - 1;
                if (m_left == 0) m_mode = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("state", 32'(bus.state), 32'(m_mode));
        chk("set_hours", 32'(bus.set_hours), 32'(m_h));
        chk("set_mins", 32'(bus.set_mins), 32'(m_m));
        chk("set_secs", 32'(bus.set_secs), 32'(m_s));
        chk("load", 32'(bus.load), 32'(m_mode == 4));
        chk("run", 32'(bus.run), 32'(m_mode == 5));
        chk("alarm", 32'(bus.alarm), 32'(m_mode == 7));
        chk("field_sel", 32'(bus.field_sel), (m_mode >= 1 && m_mode <= 3) ? 32'(m_mode) : 32'd0);
    endtask

    task automatic step(input bit r, input bit s, input bit m, input bit i, input bit t);
        @(negedge clk);
        reset         = r;
        bus.btn_start = s;
        bus.btn_mode  = m;
        bus.btn_inc   = i;
        bus.tick_1hz  = t;
        bus.cur_hours = 5'(cur_h);
        bus.cur_mins  = 6'(cur_m);
        bus.cur_secs  = 6'(cur_s);
        @(posedge clk);
        #1;
        model_update(r, s, m, i, t);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
    endtask
    task automatic press_start(); step(0, 1, 0, 0, 0); endtask
    task automatic press_mode();  step(0, 0, 1, 0, 0); endtask
    task automatic press_inc(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 1, 0);
    endtask

    initial begin
        int ticks;
        bus.btn_start = 0; bus.btn_mode = 0; bus.btn_inc = 0; bus.tick_1hz = 0;
        bus.cur_hours = 5'd1; bus.cur_mins = 6'd0; bus.cur_secs = 6'd0;

        phase = "reset";
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_run", 32'(bus.run), 32'd0);

        phase = "set_seq";
        press_mode();
        chk("first_btn", 32'(bus.state), 32'd1);
        press_inc(2); press_mode(); press_inc(5); press_mode(); press_inc(3);
        chk("preset", {bus.set_hours, 11'd0, bus.set_mins, 4'd0, bus.set_secs},
            {5'd2, 11'd0, 6'd5, 4'd0, 6'd3});
        press_start();
        chk("load_on", 32'(bus.load), 32'd1);
        idle(1);
        chk("load_off", 32'(bus.load), 32'd0);
        chk("run_on", 32'(bus.run), 32'd1);

        phase = "pause";
        press_start();
        chk("paused", 32'(bus.state), 32'd6);
        press_start();
        chk("resumed", 32'(bus.run), 32'd1);
        press_start();
        press_mode();
        chk("abort_idle", 32'(bus.state), 32'd0);
        chk("abort_secs", 32'(bus.set_secs), 32'd3);

        phase = "alarm";
        press_start(); idle(1);
        cur_h = 0; cur_m = 0; cur_s = 0;
        press_start();
        chk("alarm_enter", 32'(bus.alarm), 32'd1);
        ticks = 0;
        for (int k = 0; k < 60 && m_mode == 7; k++) begin
            if (k % 3 == 2) begin
                step(0, 0, 0, 0, 1);
                ticks++;
            end else idle(1);
        end
        chk("alarm_ticks", 32'(ticks), 32'(ALARM_SECS));
        chk("alarm_exit", 32'(bus.state), 32'd0);

        phase = "alarm_btn";
        cur_s = 5;
        press_start(); idle(1);
        cur_s = 0;
        idle(1);
        chk("alarm2", 32'(bus.state), 32'd7);
        press_inc(1);
        chk("alarm_abort", 32'(bus.state), 32'd0);
        chk("alarm_keep_m", 32'(bus.set_mins), 32'd5);

        phase = "reset_run";
        cur_h = 0; cur_m = 1; cur_s = 0;
        press_start(); idle(2);
        step(1, 0, 0, 0, 0);
        chk("rr_state", 32'(bus.state), 32'd0);
        chk("rr_hours", 32'(bus.set_hours), 32'd0);

        phase = "zero_start";
        press_start();
        chk("zs_idle", 32'(bus.state), 32'd0);
        press_mode(); press_mode(); press_mode();
        press_start();
        chk("zs_set_s", 32'(bus.state), 32'd3);
        chk("zs_load", 32'(bus.load), 32'd0);

        phase = "wrap";
        press_mode(); press_mode();
        press_inc(23);
        chk("hours_max", 32'(bus.set_hours), 32'(MAX_HOURS));
        press_inc(1);
        chk("hours_wrap", 32'(bus.set_hours), 32'd0);
        press_mode();
        press_inc(60);
        chk("mins_wrap", 32'(bus.set_mins), 32'd0);

        phase = "reset_alarm";
        press_mode(); press_inc(1);
        press_start(); idle(1);
        cur_m = 0;
        idle(1);
        chk("ra_alarm", 32'(bus.alarm), 32'd1);
        step(1, 0, 0, 0, 0);
        chk("ra_alarm_off", 32'(bus.alarm), 32'd0);
        chk("ra_secs", 32'(bus.set_secs), 32'd0);

        phase = "random";
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 11) == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    cur_h = 0; cur_m = 0; cur_s = 0;
                end else begin
                    cur_h = $urandom_range(0, 23);
                    cur_m = $urandom_range(0, 59);
                    cur_s = $urandom_range(1, 59);
                end
            end
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
